// File: rtl/stereo_view_composer.sv
// Shared frame-buffer read-address generator and registered RGB compositor for NUM_CH cameras.
// Optional macro COMPOSER_TESTPAT_EN: mode 3 emits a column ramp instead of the channel average.
module stereo_view_composer #(
    parameter int NUM_CH  = 2,
    parameter int PIX_W   = 4,
    parameter int FRAME_W = 320,
    parameter int FRAME_H = 240,
    parameter int ADDR_W  = 17,
    parameter int RD_LAT  = 1
) (
    input  logic                    clk25_i,
    input  logic                    rst_n_i,
    input  logic                    vsync_i,
    input  logic                    active_i,
    input  logic [1:0]              mode_i,
    input  logic [1:0]              ch_sel_i,
    output logic [ADDR_W-1:0]       rd_addr_o,
    input  logic [NUM_CH*PIX_W-1:0] rd_data_i,
    output logic                    pix_valid_o,
    output logic [7:0]              red_o,
    output logic [7:0]              green_o,
    output logic [7:0]              blue_o,
    output logic [7:0]              frame_cnt_o,
    output logic                    err_overrun_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_W * FRAME_H - 1);
    localparam int SUM_W  = PIX_W + 2;
    localparam int AVG_SH = $clog2(NUM_CH);

    typedef enum logic [1:0] {S_WAIT, S_ARM, S_RUN, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              err_q, err_d;
    logic [1:0]        mode_q, mode_d;
    logic [1:0]        ch_sel_q, ch_sel_d;

    logic [RD_LAT:0]   vld_q;
    logic              pix_valid_q;
    logic [7:0]        red_q, green_q, blue_q;
    logic [7:0]        red_c, green_c, blue_c;

    function automatic logic [7:0] expand(input logic [PIX_W-1:0] p);
        logic [7:0] e;
        for (int i = 0; i < 8; i++) begin
            e[7-i] = p[PIX_W-1-(i % PIX_W)];
        end
        return e;
    endfunction

    always_ff @(posedge clk25_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_WAIT;
            addr_q      <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
            mode_q      <= '0;
            ch_sel_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            mode_q      <= mode_d;
            ch_sel_q    <= ch_sel_d;
        end
    end

    // Mode and channel are only sampled while armed so a frame is never composed with mixed settings.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        mode_d      = mode_q;
        ch_sel_d    = ch_sel_q;
        case (state_q)
            S_WAIT: begin
                if (!vsync_i) state_d = S_ARM;
            end
            S_ARM: begin
                addr_d   = '0;
                mode_d   = mode_i;
                ch_sel_d = ch_sel_i;
                if (vsync_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (!vsync_i) begin
                    state_d = S_ARM;
                    addr_d  = '0;
                end else if (active_i) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d      = '0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        state_d     = S_HOLD;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            S_HOLD: begin
                addr_d = '0;
                if (active_i) err_d = 1'b1;
                if (!vsync_i) state_d = S_ARM;
            end
            default: state_d = S_WAIT;
        endcase
    end

`ifdef COMPOSER_TESTPAT_EN
    localparam int COL_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_W - 1);

    logic [COL_W-1:0] col_q;
    logic [COL_W-1:0] col_pipe_q [RD_LAT+1];
    logic [15:0]      col_ext;

    // Column tracks rd_addr mod FRAME_W and travels alongside the read latency.
    always_ff @(posedge clk25_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            col_q <= '0;
            for (int i = 0; i <= RD_LAT; i++) col_pipe_q[i] <= '0;
        end else begin
            if (addr_d == '0) begin
                col_q <= '0;
            end else if (addr_d != addr_q) begin
                col_q <= (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
            end
            col_pipe_q[0] <= col_q;
            for (int i = 1; i <= RD_LAT; i++) col_pipe_q[i] <= col_pipe_q[i-1];
        end
    end

    assign col_ext = 16'(col_pipe_q[RD_LAT]);
`endif

    logic [PIX_W-1:0] ch [NUM_CH];
    logic [PIX_W-1:0] sel_pix;
    logic [PIX_W-1:0] ch1_pix;
    logic [PIX_W-1:0] diff_pix;
`ifndef COMPOSER_TESTPAT_EN
    logic [SUM_W-1:0] sum_pix;
    logic [PIX_W-1:0] avg_pix;
`endif

    // Modes needing a second channel fall back to ch0 when only one camera exists.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) ch[i] = rd_data_i[i*PIX_W +: PIX_W];
        sel_pix = ch[0];
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel_q == 2'(i)) sel_pix = ch[i];
        end
        ch1_pix  = ch[1 % NUM_CH];
        diff_pix = (ch[0] >= ch1_pix) ? ch[0] - ch1_pix : ch1_pix - ch[0];
`ifndef COMPOSER_TESTPAT_EN
        sum_pix = '0;
        for (int i = 0; i < NUM_CH; i++) sum_pix = sum_pix + SUM_W'(ch[i]);
        avg_pix = PIX_W'(sum_pix >> AVG_SH);
`endif
        red_c   = expand(sel_pix);
        green_c = red_c;
        blue_c  = red_c;
        case (mode_q)
            2'd1: begin
                if (NUM_CH > 1) begin
                    red_c   = expand(ch[0]);
                    green_c = expand(ch1_pix);
                    blue_c  = expand(ch1_pix);
                end else begin
                    red_c   = expand(ch[0]);
                    green_c = red_c;
                    blue_c  = red_c;
                end
            end
            2'd2: begin
                red_c   = (NUM_CH > 1) ? expand(diff_pix) : expand(ch[0]);
                green_c = red_c;
                blue_c  = red_c;
            end
            2'd3: begin
`ifdef COMPOSER_TESTPAT_EN
                red_c = {col_ext[4:0], 3'b000};
`else
                red_c = expand(avg_pix);
`endif
                green_c = red_c;
                blue_c  = red_c;
            end
            default: ;
        endcase
    end

    // Valid is tapped RD_LAT+1 edges after active so RGB lines up with the buffer data.
    always_ff @(posedge clk25_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q       <= '0;
            pix_valid_q <= 1'b0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
        end else begin
            vld_q       <= {vld_q[RD_LAT-1:0], active_i && (state_q != S_WAIT)};
            pix_valid_q <= vld_q[RD_LAT];
            red_q       <= vld_q[RD_LAT] ? red_c   : 8'h00;
            green_q     <= vld_q[RD_LAT] ? green_c : 8'h00;
            blue_q      <= vld_q[RD_LAT] ? blue_c  : 8'h00;
        end
    end

    assign rd_addr_o     = addr_q;
    assign pix_valid_o   = pix_valid_q;
    assign red_o         = red_q;
    assign green_o       = green_q;
    assign blue_o        = blue_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign err_overrun_o = err_q;

endmodule

// File: tb/tb_stereo_view_composer.sv
// Directed bench for stereo_view_composer with default parameters (2 channels, 4-bit pixels, 320x240).
module tb_stereo_view_composer;

    logic        clk25 = 1'b0;
    logic        rstN;
    logic        vsync;
    logic        active;
    logic [1:0]  modeI;
    logic [1:0]  chSel;
    logic [16:0] rdAddr;
    logic [7:0]  rdData;
    logic        pixValid;
    logic [7:0]  red, green, blue;
    logic [7:0]  frameCnt;
    logic        errOverrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] chSel;
        logic [7:0] data;
        logic [7:0] expR;
        logic [7:0] expG;
        logic [7:0] expB;
    } vec_t;

    vec_t vecs [10];

`ifdef COMPOSER_TESTPAT_EN
    localparam bit TESTPAT = 1'b1;
`else
    localparam bit TESTPAT = 1'b0;
`endif

    stereo_view_composer dut (
        .clk25_i      (clk25),
        .rst_n_i      (rstN),
        .vsync_i      (vsync),
        .active_i     (active),
        .mode_i       (modeI),
        .ch_sel_i     (chSel),
        .rd_addr_o    (rdAddr),
        .rd_data_i    (rdData),
        .pix_valid_o  (pixValid),
        .red_o        (red),
        .green_o      (green),
        .blue_o       (blue),
        .frame_cnt_o  (frameCnt),
        .err_overrun_o(errOverrun)
    );

    always #5 clk25 = ~clk25;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic vs, input logic act);
        vsync  = vs;
        active = act;
        @(posedge clk25);
        #1;
    endtask

    task automatic armFrame(input logic [1:0] m, input logic [1:0] cs);
        modeI = m;
        chSel = cs;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
    endtask

    initial begin
        int badCount;

        vecs[0] = '{2'd1, 2'd0, 8'h3A, 8'hAA, 8'h33, 8'h33};
        vecs[1] = '{2'd2, 2'd0, 8'h92, 8'h77, 8'h77, 8'h77};
        vecs[2] = '{2'd3, 2'd0, 8'h0F, TESTPAT ? 8'h00 : 8'h77, TESTPAT ? 8'h00 : 8'h77, TESTPAT ? 8'h00 : 8'h77};
        vecs[3] = '{2'd0, 2'd1, 8'h5C, 8'h55, 8'h55, 8'h55};
        vecs[4] = '{2'd0, 2'd0, 8'h5C, 8'hCC, 8'hCC, 8'hCC};
        vecs[5] = '{2'd0, 2'd3, 8'h5C, 8'hCC, 8'hCC, 8'hCC};
        vecs[6] = '{2'd2, 2'd0, 8'h29, 8'h77, 8'h77, 8'h77};
        vecs[7] = '{2'd3, 2'd0, 8'hFE, TESTPAT ? 8'h00 : 8'hEE, TESTPAT ? 8'h00 : 8'hEE, TESTPAT ? 8'h00 : 8'hEE};
        vecs[8] = '{2'd1, 2'd0, 8'hF0, 8'h00, 8'hFF, 8'hFF};
        vecs[9] = '{2'd0, 2'd2, 8'hA1, 8'h11, 8'h11, 8'h11};

        rstN   = 1'b1;
        vsync  = 1'b1;
        active = 1'b0;
        modeI  = 2'd0;
        chSel  = 2'd0;
        rdData = 8'h00;
        #1 rstN = 1'b0;
        #2;
        checkOutput("reset_rd_addr", 32'(rdAddr), 32'd0);
        checkOutput("reset_pix_valid", 32'(pixValid), 32'd0);
        checkOutput("reset_rgb", 32'({red, green, blue}), 32'd0);
        checkOutput("reset_frame_cnt", 32'(frameCnt), 32'd0);
        checkOutput("reset_err_overrun", 32'(errOverrun), 32'd0);
        @(posedge clk25);
        #1 rstN = 1'b1;

        // Active before any vsync must neither move the address nor produce pixels.
        rdData = 8'h3A;
        repeat (3) applyStimulus(1'b1, 1'b1);
        checkOutput("wait_rd_addr", 32'(rdAddr), 32'd0);
        checkOutput("wait_pix_valid", 32'(pixValid), 32'd0);
        repeat (2) applyStimulus(1'b1, 1'b0);
        checkOutput("wait_pix_valid_late", 32'(pixValid), 32'd0);

        foreach (vecs[v]) begin
            rdData = vecs[v].data;
            armFrame(vecs[v].mode, vecs[v].chSel);
            applyStimulus(1'b1, 1'b1);
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("vec%0d_valid_early", v), 32'(pixValid), 32'd0);
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("vec%0d_valid", v), 32'(pixValid), 32'd1);
            checkOutput($sformatf("vec%0d_rgb", v), 32'({red, green, blue}),
                        32'({vecs[v].expR, vecs[v].expG, vecs[v].expB}));
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("vec%0d_valid_after", v), 32'(pixValid), 32'd0);
            checkOutput($sformatf("vec%0d_rgb_after", v), 32'({red, green, blue}), 32'd0);
        end

        // Short frame: vsync drops at address 500.
        rdData = 8'h3A;
        armFrame(2'd0, 2'd0);
        repeat (500) applyStimulus(1'b1, 1'b1);
        checkOutput("abort_rd_addr_before", 32'(rdAddr), 32'd500);
        applyStimulus(1'b0, 1'b0);
        checkOutput("abort_rd_addr", 32'(rdAddr), 32'd0);
        checkOutput("abort_frame_cnt", 32'(frameCnt), 32'd0);

        // Full frame in mode 0; mode input moves to 1 mid-frame and must not take effect yet.
        armFrame(2'd0, 2'd0);
        badCount = 0;
        for (int k = 0; k < 76800; k++) begin
            if (rdAddr !== 17'(k)) badCount++;
            if (k == 1000) modeI = 2'd1;
            if (k == 2000) checkOutput("midframe_mode_hold", 32'({red, green, blue}), 32'hAAAAAA);
            applyStimulus(1'b1, 1'b1);
        end
        checkOutput("frame_addr_mismatches", 32'(badCount), 32'd0);
        checkOutput("frame_end_rd_addr", 32'(rdAddr), 32'd0);
        checkOutput("frame_end_frame_cnt", 32'(frameCnt), 32'd1);
        checkOutput("frame_end_err_overrun", 32'(errOverrun), 32'd0);

        applyStimulus(1'b1, 1'b1);
        checkOutput("hold_rd_addr", 32'(rdAddr), 32'd0);
        checkOutput("overrun_set", 32'(errOverrun), 32'd1);
        repeat (2) applyStimulus(1'b1, 1'b0);
        checkOutput("overrun_sticky", 32'(errOverrun), 32'd1);

        // The mode change made during the previous frame shows up after the next vsync.
        armFrame(2'd1, 2'd0);
        checkOutput("rearm_frame_cnt", 32'(frameCnt), 32'd1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("new_mode_valid", 32'(pixValid), 32'd1);
        checkOutput("new_mode_rgb", 32'({red, green, blue}), 32'hAA3333);

        // Asynchronous reset with the frame in flight.
        repeat (997) applyStimulus(1'b1, 1'b1);
        checkOutput("pre_reset_rd_addr", 32'(rdAddr), 32'd1000);
        rstN = 1'b0;
        #2;
        checkOutput("async_reset_rd_addr", 32'(rdAddr), 32'd0);
        checkOutput("async_reset_pix_valid", 32'(pixValid), 32'd0);
        checkOutput("async_reset_rgb", 32'({red, green, blue}), 32'd0);
        checkOutput("async_reset_frame_cnt", 32'(frameCnt), 32'd0);
        checkOutput("async_reset_err_overrun", 32'(errOverrun), 32'd0);
        @(posedge clk25);
        #1 rstN = 1'b1;
        repeat (3) applyStimulus(1'b1, 1'b1);
        checkOutput("post_reset_rd_addr", 32'(rdAddr), 32'd0);
        checkOutput("post_reset_pix_valid", 32'(pixValid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
